skolem_witness_checker: RTL and testbench
=========================================

// Module: skolem_witness_checker
// PURPOSE
//  Consumer side of the Skolem-function interface: accepts (s, t, x) tuples, where x is the witness
//  a generated Skolem block produced for s and t, and checks the bvsgt/bvlshr condition (x >> s) >s t.
//  A sequential exhaustive sweep over all x establishes the invertibility condition (IC).
//  A witness passes if it satisfies the condition, or if no x satisfies it.
//  Sits between a witness generator and the regression scoreboard; keeps running pass/fail counts.
// PARAMETERS
//  W      4   operand width of s, t, x; the sweep runs over 2^W candidates
//  CNT_W  16  width of the check/fail counters
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      request valid
//  in_ready   out  1      checker can accept a request
//  in_s       in   W      shift amount s (unsigned)
//  in_t       in   W      comparison bound t (two's complement)
//  in_x       in   W      witness x under test
//  res_valid  out  1      verdict valid
//  res_ready  in   1      downstream accepts verdict
//  res_pass   out  1      1 = witness acceptable
//  res_ic     out  1      1 = some x satisfies (x >> s) >s t
//  chk_cnt    out  CNT_W  completed checks (saturating)
//  fail_cnt   out  CNT_W  completed checks with res_pass=0 (saturating)
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; in_ready=1; res_valid=0; res_pass=0; res_ic=0; counters=0.
//  - Arithmetic: lshr = logical right shift with zero fill; any s >= W gives 0.
//    Comparison is signed over W bits.
//  - FSM IDLE:
//    - in_ready=1.
//    - On in_valid&in_ready: latch s, t. Register wit_ok = ((in_x >> in_s) >s in_t).
//      Clear cand and found. Go to SWEEP.
//  - FSM SWEEP:
//    - in_ready=0; one candidate per cycle.
//    - found |= ((cand >> s) >s t); cand increments.
//    - When cand = 2^W-1 has been evaluated, go to DONE.
//    - Total: exactly 2^W SWEEP cycles.
//  - FSM DONE:
//    - res_valid=1; res_ic=found; res_pass = wit_ok | ~found.
//    - Outputs stay stable while res_ready=0.
//    - On res_ready: chk_cnt+1; fail_cnt+1 if ~res_pass (both saturate at all-ones).
//      Clear res_valid; go to IDLE.
//  - Latency: res_valid rises 2^W+1 clocks after the accepting edge (17 for W=4).
//    Throughput: one request per 2^W+2 cycles minimum.
//  - in_valid is ignored outside IDLE; no new request is captured in the cycle res_ready fires.
//  - in_x is used only at capture; input changes after capture have no effect.
//  - Reset mid-SWEEP or in DONE aborts the check; the in-flight request is lost and not counted.
// CONFIGURATION
//  EARLY_EXIT_EN defined:
//    - wit_ok=1 at capture: go directly IDLE->DONE with found=1; res_valid 1 cycle after accept.
//    - Otherwise SWEEP goes to DONE on the first cand with a true condition.
//    - res_pass/res_ic values are identical to the full-sweep build; only latency changes.
//  EARLY_EXIT_EN undefined: fixed 2^W-cycle sweep, latency constant (default build).
// TESTING
//  1. s=0, t=0101, x=0111 -> res_pass=1, res_ic=1.
//     Latency 17 (default) / 1 (EARLY_EXIT_EN); chk_cnt=1.
//  2. s=1, t=0111, x=0000 -> res_ic=0 (max x>>1 is 0111), res_pass=1; fail_cnt unchanged.
//  3. s=2, t=0001, x=0000 -> res_ic=1 (x=1111 gives 0011), res_pass=0; fail_cnt increments.
//  4. s=0100 (>=W), t=1111 -> every x gives 0 >s -1; res_ic=1, res_pass=1 for any x.
//  5. Hold res_ready=0 for 5 cycles in DONE, toggle in_valid -> outputs stable, no capture, in_ready=0;
//     counters update only on the handshake.
//  6. Assert rst at sweep cycle 8 -> all outputs at reset values immediately.
//     The next request completes normally; force chk_cnt to all-ones -> saturation holds.

Source files
------------

// File: rtl/skolem_witness_checker.sv
// Checks a Skolem witness x against (x >> s) >s t and sweeps every x to decide invertibility.
// Optional build macro EARLY_EXIT_EN: finish as soon as any candidate is known to satisfy the condition.
module skolem_witness_checker #(
   parameter int W     = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_s,
   input  logic [W-1:0]     in_t,
   input  logic [W-1:0]     in_x,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_pass,
   output logic             res_ic,
   output logic [CNT_W-1:0] chk_cnt,
   output logic [CNT_W-1:0] fail_cnt
);

   // state | meaning
   // IDLE  | ready for a request
   // SWEEP | one candidate x evaluated per cycle
   // DONE  | verdict presented until res_ready
   typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     s_q, s_d;
   logic [W-1:0]     t_q, t_d;
   logic [W-1:0]     cand_q, cand_d;
   logic             wit_ok_q, wit_ok_d;
   logic             found_q, found_d;
   logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;
   logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
   logic             hit;
   logic             wit_hit;
   logic             pass_now;

   // Shift by s >= W yields zero under SV semantics, matching logical right shift.
   function automatic logic cond_ok(input logic [W-1:0] x, input logic [W-1:0] s,
                                    input logic [W-1:0] t);
      logic [W-1:0] sh;
      sh = x >> s;
      return $signed(sh) > $signed(t);
   endfunction

   assign hit      = cond_ok(cand_q, s_q, t_q);
   assign wit_hit  = cond_ok(in_x, in_s, in_t);
   assign pass_now = wit_ok_q | ~found_q;

   always_comb begin
      state_d    = state_q;
      s_d        = s_q;
      t_d        = t_q;
      cand_d     = cand_q;
      wit_ok_d   = wit_ok_q;
      found_d    = found_q;
      chk_cnt_d  = chk_cnt_q;
      fail_cnt_d = fail_cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               s_d      = in_s;
               t_d      = in_t;
               wit_ok_d = wit_hit;
               cand_d   = '0;
               found_d  = 1'b0;
               state_d  = SWEEP;
`ifdef EARLY_EXIT_EN
               if (wit_hit) begin
                  found_d = 1'b1;
                  state_d = DONE;
               end
`endif
            end
         end
         SWEEP: begin
            found_d = found_q | hit;
            cand_d  = cand_q + W'(1);
            if (cand_q == '1)
               state_d = DONE;
`ifdef EARLY_EXIT_EN
            if (hit)
               state_d = DONE;
`endif
         end
         DONE: begin
            if (res_ready) begin
               if (chk_cnt_q != '1)
                  chk_cnt_d = chk_cnt_q + CNT_W'(1);
               if (!pass_now && fail_cnt_q != '1)
                  fail_cnt_d = fail_cnt_q + CNT_W'(1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         s_q        <= '0;
         t_q        <= '0;
         cand_q     <= '0;
         wit_ok_q   <= 1'b0;
         found_q    <= 1'b0;
         chk_cnt_q  <= '0;
         fail_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         s_q        <= s_d;
         t_q        <= t_d;
         cand_q     <= cand_d;
         wit_ok_q   <= wit_ok_d;
         found_q    <= found_d;
         chk_cnt_q  <= chk_cnt_d;
         fail_cnt_q <= fail_cnt_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign res_valid = (state_q == DONE);
   assign res_pass  = (state_q == DONE) & pass_now;
   assign res_ic    = (state_q == DONE) & found_q;
   assign chk_cnt   = chk_cnt_q;
   assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_skolem_witness_checker.sv
// Scoreboard bench: directed requests push expected verdicts/counts; a negedge monitor pops and compares.
module tb_skolem_witness_checker;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, res_ready;
   logic [3:0]  in_s, in_t, in_x;
   logic        in_ready, res_valid, res_pass, res_ic;
   logic [15:0] chk_cnt, fail_cnt;
   logic        in_ready2, res_valid2, res_pass2, res_ic2;
   logic [1:0]  chk_cnt2, fail_cnt2;

   skolem_witness_checker #(.W(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_s(in_s), .in_t(in_t), .in_x(in_x), .res_valid(res_valid), .res_ready(res_ready),
      .res_pass(res_pass), .res_ic(res_ic), .chk_cnt(chk_cnt), .fail_cnt(fail_cnt));

   // Narrow-counter copy sharing the same stimulus, used to reach saturation quickly.
   skolem_witness_checker #(.W(4), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .in_s(in_s), .in_t(in_t), .in_x(in_x), .res_valid(res_valid2), .res_ready(res_ready),
      .res_pass(res_pass2), .res_ic(res_ic2), .chk_cnt(chk_cnt2), .fail_cnt(fail_cnt2));

   always #5 clk = ~clk;

   typedef struct {
      logic pass;
      logic ic;
      int   chk;
      int   fail;
      int   chk2;
      int   fail2;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   exp_chk = 0, exp_fail = 0, exp_chk2 = 0, exp_fail2 = 0;
   logic cnt_pending = 1'b0;
   exp_t pend;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (cnt_pending) begin
         check("chk_cnt", int'(chk_cnt), pend.chk);
         check("fail_cnt", int'(fail_cnt), pend.fail);
         check("chk_cnt_narrow", int'(chk_cnt2), pend.chk2);
         check("fail_cnt_narrow", int'(fail_cnt2), pend.fail2);
         cnt_pending = 1'b0;
      end
      if (!rst && res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            pend = exp_q.pop_front();
            check("res_pass", int'(res_pass), int'(pend.pass));
            check("res_ic", int'(res_ic), int'(pend.ic));
            check("res_pass_narrow", int'(res_pass2), int'(pend.pass));
            check("res_ic_narrow", int'(res_ic2), int'(pend.ic));
            cnt_pending = 1'b1;
         end
      end
   end

   function automatic int sat(input int v, input int maxv);
      return (v >= maxv) ? maxv : v + 1;
   endfunction

   task automatic push_exp(input logic ep, input logic eic);
      exp_t e;
      exp_chk   = sat(exp_chk, 65535);
      exp_chk2  = sat(exp_chk2, 3);
      if (!ep) begin
         exp_fail  = sat(exp_fail, 65535);
         exp_fail2 = sat(exp_fail2, 3);
      end
      e.pass = ep; e.ic = eic;
      e.chk = exp_chk; e.fail = exp_fail; e.chk2 = exp_chk2; e.fail2 = exp_fail2;
      exp_q.push_back(e);
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) check("in_ready_timeout", 0, 1);
   endtask

   task automatic accept(input logic [3:0] s, input logic [3:0] t, input logic [3:0] x);
      wait_ready();
      in_s = s; in_t = t; in_x = x; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_s = ~s; in_t = ~t; in_x = ~x;
   endtask

   task automatic do_req(input logic [3:0] s, input logic [3:0] t, input logic [3:0] x,
                         input logic ep, input logic eic, input int hold);
      int   lat;
      int   c0, f0;
      push_exp(ep, eic);
      accept(s, t, x);
      lat = 1;
      while (!res_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!res_valid) check("res_valid_timeout", 0, 1);
`ifndef EARLY_EXIT_EN
      check("latency", lat, 17);
`endif
      if (hold > 0) begin
         c0 = int'(chk_cnt); f0 = int'(fail_cnt);
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            in_valid = ~in_valid;
            check("hold_valid", int'(res_valid), 1);
            check("hold_in_ready", int'(in_ready), 0);
            check("hold_pass", int'(res_pass), int'(ep));
            check("hold_ic", int'(res_ic), int'(eic));
            check("hold_chk_cnt", int'(chk_cnt), c0);
            check("hold_fail_cnt", int'(fail_cnt), f0);
         end
         in_valid = 1'b1;
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      if (hold > 0) begin
         check("no_capture_on_handshake", int'(in_ready), 1);
         in_valid = 1'b0;
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
      in_s = '0; in_t = '0; in_x = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_res_valid", int'(res_valid), 0);
      check("rst_res_pass", int'(res_pass), 0);
      check("rst_res_ic", int'(res_ic), 0);
      check("rst_chk_cnt", int'(chk_cnt), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      do_req(4'h0, 4'h5, 4'h7, 1'b1, 1'b1, 0);
      do_req(4'h1, 4'h7, 4'h0, 1'b1, 1'b0, 0);
      do_req(4'h2, 4'h1, 4'h0, 1'b0, 1'b1, 0);
      do_req(4'h4, 4'hF, 4'h9, 1'b1, 1'b1, 0);
      do_req(4'h3, 4'h0, 4'h8, 1'b1, 1'b1, 0);
      do_req(4'h3, 4'h0, 4'h7, 1'b0, 1'b1, 0);
      do_req(4'h0, 4'h7, 4'hA, 1'b1, 1'b0, 0);
      do_req(4'h0, 4'h8, 4'h8, 1'b0, 1'b1, 5);

      // Abort a check mid-sweep with reset.
      accept(4'h2, 4'h1, 4'h0);
      repeat (8) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("abort_in_ready", int'(in_ready), 1);
      check("abort_res_valid", int'(res_valid), 0);
      check("abort_res_pass", int'(res_pass), 0);
      check("abort_res_ic", int'(res_ic), 0);
      check("abort_chk_cnt", int'(chk_cnt), 0);
      check("abort_fail_cnt", int'(fail_cnt), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      exp_chk = 0; exp_fail = 0; exp_chk2 = 0; exp_fail2 = 0;

      for (int i = 0; i < 4; i++)
         do_req(4'h2, 4'h1, 4'h0, 1'b0, 1'b1, 0);

      repeat (3) @(posedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
